// File: rtl/key_loader.sv
// Bit-serial key loader: MSB-first shift over valid/ready, atomic commit to Key one cycle after last accepted bit.
// Backpressure: KeyInReady only in SHIFT/PARITY; optional even-parity check enabled by macro KEY_PARITY_EN.
module key_loader #(
  parameter int KEY_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic                 Clear,
  input  logic                 KeyIn,
  input  logic                 KeyInValid,
  output logic                 KeyInReady,
  output logic [KEY_WIDTH-1:0] Key,
  output logic                 KeyLoaded,
  output logic                 Busy,
  output logic                 Error
);

  localparam int CNT_WIDTH = $clog2(KEY_WIDTH);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(KEY_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SHIFT  = 3'd1;
  localparam logic [2:0] S_DONE   = 3'd3;
`ifdef KEY_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd2;
  localparam logic [2:0] S_ERROR  = 3'd4;
`endif

  logic [2:0]           state;
  logic [KEY_WIDTH-1:0] sr;
  logic [CNT_WIDTH-1:0] cnt;
  logic [KEY_WIDTH-1:0] shifted;
  logic                 accept;

  assign accept  = KeyInValid && KeyInReady;
  assign shifted = {sr[KEY_WIDTH-2:0], KeyIn};

`ifndef KEY_PARITY_EN
  assign Error = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= S_IDLE;
      sr         <= '0;
      cnt        <= '0;
      Key        <= '0;
      KeyLoaded  <= 1'b0;
      KeyInReady <= 1'b0;
      Busy       <= 1'b0;
`ifdef KEY_PARITY_EN
      Error      <= 1'b0;
`endif
    end else if (Clear) begin
      // Zeroise drops any partial key so none of it can ever reach Key.
      state      <= S_IDLE;
      sr         <= '0;
      cnt        <= '0;
      Key        <= '0;
      KeyLoaded  <= 1'b0;
      KeyInReady <= 1'b0;
      Busy       <= 1'b0;
`ifdef KEY_PARITY_EN
      Error      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            state      <= S_SHIFT;
            sr         <= '0;
            cnt        <= '0;
            KeyInReady <= 1'b1;
            Busy       <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (accept) begin
            sr <= shifted;
            if (cnt == LAST) begin
`ifdef KEY_PARITY_EN
              state      <= S_PARITY;
`else
              state      <= S_DONE;
              Key        <= shifted;
              KeyLoaded  <= 1'b1;
              KeyInReady <= 1'b0;
              Busy       <= 1'b0;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
`ifdef KEY_PARITY_EN
        S_PARITY: begin
          if (accept) begin
            KeyInReady <= 1'b0;
            Busy       <= 1'b0;
            if (^{sr, KeyIn} == 1'b0) begin
              state     <= S_DONE;
              Key       <= sr;
              KeyLoaded <= 1'b1;
            end else begin
              state <= S_ERROR;
              Error <= 1'b1;
            end
          end
        end
        S_ERROR: begin
          if (Start) begin
            state      <= S_SHIFT;
            sr         <= '0;
            cnt        <= '0;
            Error      <= 1'b0;
            KeyInReady <= 1'b1;
            Busy       <= 1'b1;
          end
        end
`endif
        // Write-once: DONE holds the key until Clear or reset.
        S_DONE: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_loader.sv
// Directed bench for key_loader with a bit-count/accumulator reference model checked every cycle.
module tb_key_loader;
  localparam int W = 16;
`ifdef KEY_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         Start = 1'b0;
  logic         Clear = 1'b0;
  logic         KeyIn = 1'b0;
  logic         KeyInValid = 1'b0;
  logic         KeyInReady;
  logic [W-1:0] Key;
  logic         KeyLoaded;
  logic         Busy;
  logic         Error;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 Clk = ~Clk;

  key_loader #(.KEY_WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Clear(Clear), .KeyIn(KeyIn),
    .KeyInValid(KeyInValid), .KeyInReady(KeyInReady), .Key(Key),
    .KeyLoaded(KeyLoaded), .Busy(Busy), .Error(Error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts received bits and accumulates them as an integer.
  bit           m_loading, m_loaded, m_error;
  int           m_count;
  longint       m_bits;
  logic [W-1:0] m_key;

  always @(posedge Clk or posedge Rst) begin
    if (Rst || Clear) begin
      m_loading = 0; m_loaded = 0; m_error = 0;
      m_count = 0; m_bits = 0; m_key = '0;
    end else if (m_loading) begin
      if (KeyInValid) begin
        m_bits = (m_bits << 1) | longint'(KeyIn);
        m_count++;
        if (m_count == NB) begin
          m_loading = 0;
          if (NB == W) begin
            m_key = W'(m_bits);
            m_loaded = 1;
          end else if ($countones(m_bits) % 2 == 0) begin
            m_key = W'(m_bits >> 1);
            m_loaded = 1;
          end else begin
            m_error = 1;
          end
        end
      end
    end else if (!m_loaded && Start) begin
      m_loading = 1; m_error = 0; m_count = 0; m_bits = 0;
    end
  end

  initial forever begin
    @(posedge Clk);
    #3;
    if (!Rst && chk_en) begin
      chk("model_key",   32'(Key),        32'(m_key));
      chk("model_loaded", 32'(KeyLoaded), 32'(m_loaded));
      chk("model_ready", 32'(KeyInReady), 32'(m_loading));
      chk("model_busy",  32'(Busy),       32'(m_loading));
      chk("model_error", 32'(Error),      32'(m_error));
    end
  end

  function automatic logic [W:0] fmt(input logic [W-1:0] k, input logic p);
    return (NB == W) ? {1'b0, k} : {k, p};
  endfunction

  // Pulses Start, then sends n bits MSB first; returns just before the edge that takes the last bit.
  task automatic load(input logic [W:0] bits, input int n, input bit gap, output logic [W-1:0] key_pre);
    int tries;
    key_pre = '0;
    @(negedge Clk);
    Start = 1'b1;
    for (int i = 0; i < n; i++) begin
      tries = 0;
      forever begin
        @(negedge Clk);
        Start = 1'b0;
        KeyInValid = 1'b1;
        KeyIn = bits[n-1-i];
        if (KeyInReady) break;
        tries++;
        if (tries > 20) begin
          n_vec++; n_err++;
          $display("FAIL accept_timeout: bit %0d never accepted, ready=%b required 1", i, KeyInReady);
          KeyInValid = 1'b0;
          return;
        end
      end
      if (i == n - 1) key_pre = Key;
      else if (gap) begin
        @(negedge Clk);
        KeyInValid = 1'b0;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_key"},    32'(Key),        32'h0);
    chk({tag, "_loaded"}, 32'(KeyLoaded),  32'h0);
    chk({tag, "_ready"},  32'(KeyInReady), 32'h0);
    chk({tag, "_busy"},   32'(Busy),       32'h0);
    chk({tag, "_error"},  32'(Error),      32'h0);
  endtask

  initial begin
    logic [W-1:0] pre;
    @(negedge Clk);
    chk_all_zero("reset");
    @(negedge Clk);
    Rst = 1'b0;
    chk_en = 1'b1;

    // Continuous load; key must appear exactly one edge after the last accept.
    load(fmt(16'hA5C3, 1'b0), NB, 1'b0, pre);
    chk("a5c3_pre_commit", 32'(pre), 32'h0);
    @(posedge Clk); #2;
    chk("a5c3_key", 32'(Key), 32'hA5C3);
    chk("a5c3_loaded", 32'(KeyLoaded), 32'h1);
    @(negedge Clk); KeyInValid = 1'b0;

    Clear = 1'b1;
    @(negedge Clk); Clear = 1'b0;
    chk("clear1_key", 32'(Key), 32'h0);

    // Toggling valid.
    load(fmt(16'h1234, 1'b1), NB, 1'b1, pre);
    chk("1234_pre_commit", 32'(pre), 32'h0);
    @(posedge Clk); #2;
    chk("1234_key", 32'(Key), 32'h1234);
    @(negedge Clk); KeyInValid = 1'b0;

    // Second load attempt while DONE must be ignored.
    Start = 1'b1;
    @(negedge Clk); Start = 1'b0; KeyInValid = 1'b1; KeyIn = 1'b1;
    repeat (NB) @(negedge Clk);
    KeyInValid = 1'b0;
    chk("writeonce_ready", 32'(KeyInReady), 32'h0);
    chk("writeonce_key", 32'(Key), 32'h1234);
    chk("writeonce_loaded", 32'(KeyLoaded), 32'h1);

    Clear = 1'b1;
    @(negedge Clk); Clear = 1'b0;
    chk("clear2_key", 32'(Key), 32'h0);
    chk("clear2_busy", 32'(Busy), 32'h0);

    // Valid bits while idle have no effect.
    KeyInValid = 1'b1; KeyIn = 1'b1;
    repeat (4) @(negedge Clk);
    KeyInValid = 1'b0;
    chk("idle_valid_busy", 32'(Busy), 32'h0);

    // Clear mid-load together with Start.
    load(17'h000A5, 8, 1'b0, pre);
    @(negedge Clk);
    KeyInValid = 1'b0; Clear = 1'b1; Start = 1'b1;
    @(negedge Clk);
    Clear = 1'b0; Start = 1'b0;
    chk("clrstart_key", 32'(Key), 32'h0);
    chk("clrstart_ready", 32'(KeyInReady), 32'h0);
    repeat (3) @(negedge Clk);
    chk("clrstart_no_load", 32'(Busy), 32'h0);

    load(fmt(16'h5AF0, 1'b0), NB, 1'b0, pre);
    @(posedge Clk); #2;
    chk("5af0_key", 32'(Key), 32'h5AF0);
    @(negedge Clk); KeyInValid = 1'b0;

    // Asynchronous reset mid-cycle clears outputs immediately.
    @(posedge Clk); #1;
    Rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(negedge Clk); Rst = 1'b0;

`ifdef KEY_PARITY_EN
    load(fmt(16'hA5C3, 1'b1), NB, 1'b0, pre);
    @(posedge Clk); #2;
    chk("par_bad_error", 32'(Error), 32'h1);
    chk("par_bad_key", 32'(Key), 32'h0);
    chk("par_bad_loaded", 32'(KeyLoaded), 32'h0);
    @(negedge Clk); KeyInValid = 1'b0;
    load(fmt(16'hA5C3, 1'b0), NB, 1'b0, pre);
    @(posedge Clk); #2;
    chk("par_good_error", 32'(Error), 32'h0);
    chk("par_good_key", 32'(Key), 32'hA5C3);
    @(negedge Clk); KeyInValid = 1'b0;
`endif

    repeat (2) @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
    $fatal(1);
  end

endmodule
